// File: rtl/obi_mon_pkg.sv
// obi_mon_pkg: error-bit map, queued transaction type and byte-enable legality helper; ts field present with `OBI_MON_LATENCY_STATS_EN
package obi_mon_pkg;
  localparam int ERR_SPURIOUS_RVALID = 0;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_REQ_UNSTABLE = 2;
  localparam int ERR_REQ_RETRACT = 3;
  localparam int ERR_TIMEOUT = 4;
  localparam int ERR_BE_MISALIGN = 5;
  localparam int ERR_RDATA_X = 6;
  localparam int ERR_W = 7;
  localparam int TXN_ADDR_W = 32;
  localparam int TXN_BE_W = 4;
  localparam int TXN_TS_W = 16;
  typedef struct packed {
    logic we;
    logic [TXN_ADDR_W-1:0] addr;
    logic [TXN_BE_W-1:0] be;
`ifdef OBI_MON_LATENCY_STATS_EN
    logic [TXN_TS_W-1:0] ts;
`endif
  } obi_txn_t;
  function automatic logic be_addr_legal(input logic [3:0] be, input logic [1:0] addr_lo);
    return ($onehot(be) && be[addr_lo]) ||
           (be == 4'b0011 && addr_lo == 2'd0) ||
           (be == 4'b1100 && addr_lo == 2'd2) ||
           (be == 4'b1111 && addr_lo == 2'd0);
  endfunction
endpackage

// File: rtl/obi_mon_fifo.sv
// obi_mon_fifo: outstanding-transaction queue; push while full is dropped unless a pop happens the same cycle
module obi_mon_fifo
  import obi_mon_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH+1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic pop,
  input obi_txn_t din,
  output obi_txn_t dout,
  output logic full,
  output logic empty,
  output logic [CW-1:0] count
);
  obi_txn_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH-1) ? '0 : p + PW'(1);
  endfunction
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/obi_data_protocol_monitor.sv
// obi_data_protocol_monitor: passive OBI data-channel checker with counters; `OBI_MON_LATENCY_STATS_EN adds grant-to-rvalid latency stats
module obi_data_protocol_monitor
  import obi_mon_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W = 16,
  localparam int BE_W = DATA_W/8,
  localparam int OW = $clog2(MAX_OUTSTANDING+1)
)(
  input logic clk,
  input logic rst_n,
  input logic data_req_o,
  input logic data_we_o,
  input logic [ADDR_W-1:0] data_addr_o,
  input logic [BE_W-1:0] data_be_o,
  input logic [DATA_W-1:0] data_wdata_o,
  input logic data_gnt_i,
  input logic data_rvalid_i,
  input logic [DATA_W-1:0] data_rdata_i,
  input logic clr_i,
  output logic [ERR_W-1:0] err_o,
  output logic err_pulse_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [OW-1:0] outstanding_o,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic [CNT_W-1:0] wr_cnt_o,
  output logic rsp_valid_o,
  output logic rsp_we_o,
`ifdef OBI_MON_LATENCY_STATS_EN
  output logic [CNT_W-1:0] lat_min_o,
  output logic [CNT_W-1:0] lat_max_o,
  output logic [CNT_W-1:0] lat_sum_o,
`endif
  output logic [ADDR_W-1:0] rsp_addr_o
);
  localparam int AW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC+1) : 1;
  obi_txn_t push_txn, head;
  logic full, empty, acc, pop;
  logic [ERR_W-1:0] err_new;
  logic prev_pend, prev_we;
  logic [ADDR_W-1:0] prev_addr;
  logic [BE_W-1:0] prev_be;
  logic [DATA_W-1:0] prev_wdata;
  logic [AW-1:0] age;
  logic to_done;
  logic unused_be;
  assign acc = data_req_o && data_gnt_i;
  assign pop = data_rvalid_i && !empty;
  assign unused_be = ^head.be;
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic en);
    return (en && !(&c)) ? c + CNT_W'(1) : c;
  endfunction
  obi_mon_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(acc),
    .pop(data_rvalid_i),
    .din(push_txn),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(outstanding_o)
  );
`ifdef OBI_MON_LATENCY_STATS_EN
  logic [CNT_W-1:0] ts_cnt, lat, min_base, max_base, sum_base;
  logic [CNT_W:0] sum_ext;
  always_comb begin
    lat = ts_cnt - CNT_W'(head.ts);
    min_base = clr_i ? '1 : lat_min_o;
    max_base = clr_i ? '0 : lat_max_o;
    sum_base = clr_i ? '0 : lat_sum_o;
    sum_ext = {1'b0, sum_base} + {1'b0, lat};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ts_cnt <= '0;
      lat_min_o <= '1;
      lat_max_o <= '0;
      lat_sum_o <= '0;
    end else begin
      ts_cnt <= ts_cnt + CNT_W'(1);
      lat_min_o <= (pop && lat < min_base) ? lat : min_base;
      lat_max_o <= (pop && lat > max_base) ? lat : max_base;
      lat_sum_o <= !pop ? sum_base : sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
    end
`endif
  always_comb begin
    push_txn = '0;
    push_txn.we = data_we_o;
    push_txn.addr = TXN_ADDR_W'(data_addr_o);
    push_txn.be = TXN_BE_W'(data_be_o);
`ifdef OBI_MON_LATENCY_STATS_EN
    push_txn.ts = TXN_TS_W'(ts_cnt);
`endif
  end
  always_comb begin
    err_new = '0;
    err_new[ERR_SPURIOUS_RVALID] = data_rvalid_i && empty;
    err_new[ERR_OVERFLOW] = acc && full && !data_rvalid_i;
    err_new[ERR_REQ_UNSTABLE] = prev_pend && data_req_o &&
      ({data_we_o, data_addr_o, data_be_o, data_wdata_o} != {prev_we, prev_addr, prev_be, prev_wdata});
    err_new[ERR_REQ_RETRACT] = prev_pend && !data_req_o;
    err_new[ERR_TIMEOUT] = (TIMEOUT_CYC != 0) && !empty && !data_rvalid_i && !to_done && age == AW'(TIMEOUT_CYC-1);
    err_new[ERR_BE_MISALIGN] = acc && !be_addr_legal(4'(data_be_o), data_addr_o[1:0]);
`ifndef SYNTHESIS
    err_new[ERR_RDATA_X] = pop && !head.we && $isunknown(data_rdata_i);
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_pend <= 1'b0;
      prev_we <= 1'b0;
      prev_addr <= '0;
      prev_be <= '0;
      prev_wdata <= '0;
    end else begin
      prev_pend <= data_req_o && !data_gnt_i;
      prev_we <= data_we_o;
      prev_addr <= data_addr_o;
      prev_be <= data_be_o;
      prev_wdata <= data_wdata_o;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      age <= '0;
      to_done <= 1'b0;
    end else if (empty || pop) begin
      age <= '0;
      to_done <= 1'b0;
    end else begin
      age <= (to_done || TIMEOUT_CYC == 0) ? age : age + AW'(1);
      to_done <= to_done || err_new[ERR_TIMEOUT];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_o <= '0;
      err_pulse_o <= 1'b0;
      err_cnt_o <= '0;
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_we_o <= 1'b0;
      rsp_addr_o <= '0;
    end else begin
      err_o <= (clr_i ? '0 : err_o) | err_new;
      err_pulse_o <= |err_new;
      err_cnt_o <= bump(clr_i ? '0 : err_cnt_o, |err_new);
      rd_cnt_o <= bump(clr_i ? '0 : rd_cnt_o, pop && !head.we);
      wr_cnt_o <= bump(clr_i ? '0 : wr_cnt_o, pop && head.we);
      rsp_valid_o <= pop;
      if (pop) rsp_we_o <= head.we;
      if (pop) rsp_addr_o <= ADDR_W'(head.addr);
    end
endmodule
